// File: rtl/fdtd_hsweep_ctrl.sv
// fdtd_hsweep_ctrl: sequences one 1-D FDTD H-field sweep H[i] <= sat(H[i] + coef*(E[i+1]-E[i])); host owns the H buffer when idle
//   CLK, RST          : clock, asynchronous active-high reset
//   start, len, coef  : sweep request, cell count and Q(COEF_FRAC) coefficient, latched at start
//   busy, done        : not-idle flag, one-cycle end-of-sweep pulse
//   e_*               : E-buffer read port (combinational e_dout)
//   h_*               : H-buffer write port A / read port B (combinational h_dout)
//   host_*            : host access to the H buffer, granted only while idle and no start
module fdtd_hsweep_ctrl #(
  parameter int FDTD_DATA_WIDTH   = 32,
  parameter int BUFFER_ADDR_WIDTH = 6,
  parameter int COEF_FRAC         = 16
) (
  input  logic                         CLK,
  input  logic                         RST,
  input  logic                         start,
  input  logic [BUFFER_ADDR_WIDTH-1:0] len,
  input  logic [FDTD_DATA_WIDTH-1:0]   coef,
  output logic                         busy,
  output logic                         done,
  output logic                         e_en,
  output logic                         e_rden,
  output logic [BUFFER_ADDR_WIDTH-1:0] e_addr_b,
  input  logic [FDTD_DATA_WIDTH-1:0]   e_dout,
  output logic                         h_en,
  output logic                         h_wren,
  output logic                         h_rden,
  output logic [BUFFER_ADDR_WIDTH-1:0] h_addr_a,
  output logic [BUFFER_ADDR_WIDTH-1:0] h_addr_b,
  output logic [FDTD_DATA_WIDTH-1:0]   h_din,
  input  logic [FDTD_DATA_WIDTH-1:0]   h_dout,
  input  logic                         host_req,
  input  logic                         host_we,
  input  logic [BUFFER_ADDR_WIDTH-1:0] host_addr,
  input  logic [FDTD_DATA_WIDTH-1:0]   host_wdata,
  output logic                         host_gnt,
  output logic [FDTD_DATA_WIDTH-1:0]   host_rdata
);
  localparam int DW = FDTD_DATA_WIDTH;
  localparam int AW = BUFFER_ADDR_WIDTH;
  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_LOAD  = 3'd1;
  localparam logic [2:0] S_CALC  = 3'd2;
  localparam logic [2:0] S_WRITE = 3'd3;
  localparam logic [2:0] S_DONE  = 3'd4;
  logic [2:0]    state_q, state_d;
  logic [AW-1:0] i_q, i_d, len_q, len_d;
  logic [DW-1:0] e0_q, e0_d, e1_q, e1_d, acc_q, acc_d, coef_q, coef_d;
  logic signed [DW:0]     diff;
  logic signed [2*DW:0]   prod, shr;
  logic signed [2*DW+1:0] sum;
  logic [DW-1:0]          sat;
  always_comb begin
    diff = $signed({e_dout[DW-1], e_dout}) - $signed({e0_q[DW-1], e0_q});
    // low 2*DW+1 bits of the product are exact for sign-extended operands
    prod = {{(DW+1){coef_q[DW-1]}}, coef_q} * {{DW{diff[DW]}}, diff};
    shr  = prod >>> COEF_FRAC;
    sum  = {{(DW+2){h_dout[DW-1]}}, h_dout} + {shr[2*DW], shr};
    // in range only if every bit from the DW-1 sign position upward agrees
    sat  = (&sum[2*DW+1:DW-1] || ~|sum[2*DW+1:DW-1]) ? sum[DW-1:0]
         : (sum[2*DW+1] ? {1'b1, {(DW-1){1'b0}}} : {1'b0, {(DW-1){1'b1}}});
    state_d    = state_q;
    i_d        = i_q;
    len_d      = len_q;
    coef_d     = coef_q;
    e0_d       = e0_q;
    e1_d       = e1_q;
    acc_d      = acc_q;
    busy       = state_q != S_IDLE;
    done       = state_q == S_DONE;
    e_en       = 1'b0;
    e_rden     = 1'b0;
    e_addr_b   = '0;
    h_en       = 1'b0;
    h_wren     = 1'b0;
    h_rden     = 1'b0;
    h_addr_a   = '0;
    h_addr_b   = '0;
    h_din      = '0;
    host_gnt   = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          len_d   = len;
          coef_d  = coef;
          i_d     = '0;
          state_d = (len >= AW'(2)) ? S_LOAD : S_DONE;
        end else if (host_req) begin
          host_gnt = 1'b1;
          h_en     = 1'b1;
          h_wren   = host_we;
          h_rden   = !host_we;
          h_addr_a = host_addr;
          h_addr_b = host_addr;
          h_din    = host_wdata;
        end
      end
      S_LOAD: begin
        e_en     = 1'b1;
        e_rden   = 1'b1;
        e_addr_b = i_q;
        e0_d     = e_dout;
        state_d  = S_CALC;
      end
      S_CALC: begin
        e_en     = 1'b1;
        e_rden   = 1'b1;
        e_addr_b = i_q + AW'(1);
        h_en     = 1'b1;
        h_rden   = 1'b1;
        h_addr_b = i_q;
        e1_d     = e_dout;
        acc_d    = sat;
        state_d  = S_WRITE;
      end
      S_WRITE: begin
        h_en     = 1'b1;
        h_wren   = 1'b1;
        h_addr_a = i_q;
        h_din    = acc_q;
        e0_d     = e1_q;
        i_d      = (i_q == len_q - AW'(2)) ? i_q : i_q + AW'(1);
        state_d  = (i_q == len_q - AW'(2)) ? S_DONE : S_CALC;
      end
      S_DONE: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
    host_rdata = (host_gnt && !host_we) ? h_dout : '0;
  end
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q <= S_IDLE;
      i_q     <= '0;
      len_q   <= '0;
      coef_q  <= '0;
      e0_q    <= '0;
      e1_q    <= '0;
      acc_q   <= '0;
    end else begin
      state_q <= state_d;
      i_q     <= i_d;
      len_q   <= len_d;
      coef_q  <= coef_d;
      e0_q    <= e0_d;
      e1_q    <= e1_d;
      acc_q   <= acc_d;
    end
  end
endmodule

// File: tb/tb_fdtd_hsweep_ctrl.sv
// tb_fdtd_hsweep_ctrl: directed self-checking bench for fdtd_hsweep_ctrl with behavioural E/H buffers
module tb_fdtd_hsweep_ctrl;
  logic        CLK = 1'b0;
  logic        RST = 1'b1;
  logic        start = 1'b0;
  logic [5:0]  len = '0;
  logic [31:0] coef = '0;
  logic        busy, done, e_en, e_rden, h_en, h_wren, h_rden, host_gnt;
  logic [5:0]  e_addr_b, h_addr_a, h_addr_b;
  logic [31:0] e_dout, h_din, h_dout, host_rdata;
  logic        host_req = 1'b0;
  logic        host_we = 1'b0;
  logic [5:0]  host_addr = '0;
  logic [31:0] host_wdata = '0;
  logic [31:0] e_mem [64];
  logic [31:0] h_mem [64];
  logic [31:0] bm, dm, wm;
  int tests = 0;
  int fails = 0;
  fdtd_hsweep_ctrl dut (
    .CLK(CLK), .RST(RST), .start(start), .len(len), .coef(coef),
    .busy(busy), .done(done), .e_en(e_en), .e_rden(e_rden), .e_addr_b(e_addr_b),
    .e_dout(e_dout), .h_en(h_en), .h_wren(h_wren), .h_rden(h_rden),
    .h_addr_a(h_addr_a), .h_addr_b(h_addr_b), .h_din(h_din), .h_dout(h_dout),
    .host_req(host_req), .host_we(host_we), .host_addr(host_addr),
    .host_wdata(host_wdata), .host_gnt(host_gnt), .host_rdata(host_rdata)
  );
  always #5 CLK = ~CLK;
  assign e_dout = (e_en && e_rden) ? e_mem[e_addr_b] : '0;
  assign h_dout = (h_en && h_rden) ? h_mem[h_addr_b] : '0;
  always @(posedge CLK) if (h_en && h_wren) h_mem[h_addr_a] <= h_din;
  wire any_out = busy | done | e_en | e_rden | (|e_addr_b) | h_en | h_wren | h_rden |
                 (|h_addr_a) | (|h_addr_b) | (|h_din) | host_gnt | (|host_rdata);
  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic load(input logic [31:0] e0, e1, e2, e3, h0);
    e_mem[0] = e0; e_mem[1] = e1; e_mem[2] = e2; e_mem[3] = e3;
    for (int k = 0; k < 64; k++) h_mem[k] <= '0;
    h_mem[0] <= h0;
    @(negedge CLK);
  endtask
  task automatic sweep(input int n, input logic [31:0] c);
    int lim;
    lim = (n < 2) ? 2 : 2 * n + 1;
    bm = '0; dm = '0; wm = '0;
    @(negedge CLK);
    start = 1'b1; len = 6'(n); coef = c;
    @(negedge CLK);
    start = 1'b0;
    for (int k = 1; k <= lim; k++) begin
      bm[k] = busy; dm[k] = done; wm[k] = h_wren;
      @(negedge CLK);
    end
  endtask
  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end
  initial begin
    for (int k = 0; k < 64; k++) e_mem[k] = '0;
    #1;
    check("reset_outputs", any_out, 0);
    @(negedge CLK); @(negedge CLK);
    RST = 1'b0;
    load(0, 10, 30, 60, 0);
    sweep(4, 32'h0001_0000);
    check("basic_h0", h_mem[0], 10);
    check("basic_h1", h_mem[1], 20);
    check("basic_h2", h_mem[2], 30);
    check("basic_h3", h_mem[3], 0);
    check("basic_busy", bm, 32'h1FE);
    check("basic_done", dm, 32'h100);
    check("basic_wren", wm, 32'hA8);
    load(0, 7, 0, 0, 100);
    sweep(2, 32'hFFFF_8000);
    check("neg_h0", h_mem[0], 96);
    check("neg_busy", bm, 32'h1E);
    check("neg_done", dm, 32'h10);
    check("neg_wren", wm, 32'h08);
    load(0, 32'h100, 0, 0, 32'h7FFF_FFF0);
    sweep(2, 32'h0001_0000);
    check("sat_pos", h_mem[0], 32'h7FFF_FFFF);
    load(32'h100, 0, 0, 0, 32'h8000_0010);
    sweep(2, 32'h0001_0000);
    check("sat_neg", h_mem[0], 32'h8000_0000);
    load(0, 5, 0, 0, 7);
    sweep(1, 32'h0001_0000);
    check("len1_busy", bm, 32'h2);
    check("len1_done", dm, 32'h2);
    check("len1_wren", wm, 0);
    sweep(0, 32'h0001_0000);
    check("len0_busy", bm, 32'h2);
    check("len0_done", dm, 32'h2);
    check("len0_wren", wm, 0);
    check("len_h0", h_mem[0], 7);
    load(0, 10, 30, 60, 0);
    @(negedge CLK);
    start = 1'b1; len = 6'd4; coef = 32'h0001_0000;
    @(negedge CLK);
    start = 1'b0;
    @(negedge CLK); @(negedge CLK); @(negedge CLK);
    RST = 1'b1;
    #1;
    check("midrst_outputs", any_out, 0);
    @(negedge CLK);
    check("midrst_done1", done, 0);
    @(negedge CLK);
    check("midrst_done2", done, 0);
    RST = 1'b0;
    @(negedge CLK);
    check("midrst_h0", h_mem[0], 10);
    check("midrst_h1", h_mem[1], 0);
    check("midrst_idle", busy, 0);
    load(0, 3, 0, 0, 0);
    start = 1'b1; len = 6'd2; coef = 32'h0001_0000;
    host_req = 1'b1; host_we = 1'b1; host_addr = 6'd5; host_wdata = 32'hA5;
    #1;
    check("arb_gnt_c0", host_gnt, 0);
    for (int k = 1; k <= 4; k++) begin
      @(negedge CLK);
      start = 1'b0;
      #1;
      check($sformatf("arb_gnt_c%0d", k), host_gnt, 0);
    end
    @(negedge CLK);
    #1;
    check("arb_gnt_c5", host_gnt, 1);
    @(negedge CLK);
    host_req = 1'b0;
    check("arb_h5", h_mem[5], 32'hA5);
    check("arb_sweep_h0", h_mem[0], 3);
    host_req = 1'b1; host_we = 1'b0;
    #1;
    check("rd_gnt", host_gnt, 1);
    check("rd_data", host_rdata, 32'hA5);
    @(negedge CLK);
    host_req = 1'b0;
    #1;
    check("rd_idle_data", host_rdata, 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
